// File: rtl/hdmi_pll_ctrl_pkg.sv
// HDMI PLL reset supervisor: shared state encoding and timer sizing.
// No ports; imported by hdmi_pll_reset_ctrl.
`timescale 1ns/1ps
package hdmi_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_READY     = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  // Width that holds the largest of the three phase lengths.
  function automatic int unsigned timer_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hdmi_pll_lock_sync.sv
// Multi-flop synchronizer for asynchronous PLL lock indications.
// Ports: clk_i, rst_i (async high), d_i async in, q_o synchronized out.
`timescale 1ns/1ps
module hdmi_pll_lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hdmi_pll_reset_ctrl.sv
// HDMI pixel PLL supervisor: reset pulse, lock debounce, retry, fail.
// Ports: refclk, rst, pll_locked_in, relock_req -> pll_rst_out, status.
`timescale 1ns/1ps
module hdmi_pll_reset_ctrl
  import hdmi_pll_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned RST_PULSE_CYCLES    = 100,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked_in,
  input  logic             relock_req,
  output logic             pll_rst_out,
  output logic             pll_ready,
  output logic             pll_fail,
  output logic [3:0]       retry_count,
  output logic [CNT_W-1:0] lost_lock_count,
  output logic [2:0]       state_o
);

  localparam int unsigned TW = timer_width(
    RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

  // Timer holds cycles-in-state minus one, so compare against N-1.
  localparam logic [TW-1:0] RST_LAST = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RTY_MAX  = 4'(MAX_RETRIES);

  logic lock_s;

  hdmi_pll_lock_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i(refclk),
    .rst_i(rst),
    .d_i  (pll_locked_in),
    .q_o  (lock_s)
  );

  pll_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [3:0]       retry_q, retry_d;
  logic [CNT_W-1:0] lost_q, lost_d;
  logic             rst_out_q, ready_q, fail_q;
  logic [3:0]       retry_inc;

  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    unique case (state_q)
      ST_RESET_PLL: begin
        if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABILIZE;
        end else if (timer_q == TO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RTY_MAX) ? ST_FAIL : ST_RESET_PLL;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (timer_q == STB_LAST) begin
          state_d = ST_READY;
          retry_d = '0;
        end
      end
      ST_READY: begin
        // Lock loss wins over a simultaneous relock request.
        if (!lock_s) begin
          state_d = ST_RESET_PLL;
          if (lost_q != '1) lost_d = lost_q + CNT_W'(1);
        end else if (relock_req) begin
          state_d = ST_RESET_PLL;
          retry_d = '0;
        end
      end
      ST_FAIL: begin
        if (relock_req) begin
          state_d = ST_RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = ST_RESET_PLL;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == ST_RESET_PLL ||
                 state_q == ST_WAIT_LOCK ||
                 state_q == ST_STABILIZE) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      timer_q   <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      rst_out_q <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
      ready_q   <= (state_d == ST_READY);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign pll_rst_out     = rst_out_q;
  assign pll_ready       = ready_q;
  assign pll_fail        = fail_q;
  assign retry_count     = retry_q;
  assign lost_lock_count = lost_q;
  assign state_o         = state_q;

endmodule
